// File: rtl/inst_prefetch.sv
// inst_prefetch: burst instruction prefetch from Avalon-MM into a PC-tagged FIFO feeding decode.
// Ports: clk/rst (sync, active-high); o_inst_addr/o_inst_burstcount/o_inst_read/i_inst_waitrequest/
// i_inst_readdata/i_inst_readdatavalid form the burst read master; i_redirect/i_redirect_pc flush and
// retarget fetch; o_inst/o_pc/o_valid/i_ready is the decode handshake; o_busy is high outside IDLE.
// Optional INST_PREFETCH_STATS_EN adds saturating counters o_stat_words and o_stat_discard.
module inst_prefetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BURST = 4,
  parameter int DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] o_inst_addr,
  output logic [7:0]        o_inst_burstcount,
  output logic              o_inst_read,
  input  logic              i_inst_waitrequest,
  input  logic [DATA_W-1:0] i_inst_readdata,
  input  logic              i_inst_readdatavalid,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [DATA_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy
`ifdef INST_PREFETCH_STATS_EN
  ,
  output logic [31:0]       o_stat_words,
  output logic [31:0]       o_stat_discard
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] MAX_FILL = CW'(DEPTH - BURST);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4 * BURST);
  typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;
  state_t state;
  logic [ADDR_W-1:0] fetch_pc, beat_pc;
  logic [BW-1:0] beats_left;
  logic redir_pend;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_pc [DEPTH];
  logic [PW-1:0] wptr, rptr, rptr_n;
  logic [CW-1:0] cnt, cnt_n, cnt_kept;
  logic push, pop, beat_last;
  assign o_inst_burstcount = 8'(BURST);
  always_comb begin
    push = state == DATA && i_inst_readdatavalid && !i_redirect;
    pop = o_valid && i_ready;
    beat_last = beats_left == BW'(1);
    rptr_n = rptr + PW'(pop);
    cnt_kept = cnt - CW'(pop);
    cnt_n = cnt_kept + CW'(push);
  end
  // o_inst/o_pc mirror the FIFO head; when the FIFO would otherwise be empty the new beat bypasses into them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr] <= i_inst_readdata;
      mem_pc[wptr] <= beat_pc;
    end
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      o_valid <= 1'b0;
      o_inst <= '0;
      o_pc <= '0;
    end else if (i_redirect) begin
      rptr <= wptr;
      cnt <= '0;
      o_valid <= 1'b0;
    end else begin
      wptr <= wptr + PW'(push);
      rptr <= rptr_n;
      cnt <= cnt_n;
      o_valid <= cnt_n != '0;
      if (cnt_kept != '0) begin
        o_inst <= mem_data[rptr_n];
        o_pc <= mem_pc[rptr_n];
      end else if (push) begin
        o_inst <= i_inst_readdata;
        o_pc <= beat_pc;
      end
    end
  end
  // A redirect while a request is stalled must keep the request up; redir_pend turns its burst into a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      o_busy <= 1'b0;
      o_inst_read <= 1'b0;
      o_inst_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      beat_pc <= RESET_PC;
      beats_left <= '0;
      redir_pend <= 1'b0;
    end else begin
      if (i_redirect) fetch_pc <= i_redirect_pc;
      case (state)
        IDLE: if (!i_redirect && cnt <= MAX_FILL) begin
          state <= REQ;
          o_busy <= 1'b1;
          o_inst_read <= 1'b1;
          o_inst_addr <= fetch_pc;
          redir_pend <= 1'b0;
        end
        REQ: if (!i_inst_waitrequest) begin
          o_inst_read <= 1'b0;
          beats_left <= BW'(BURST);
          beat_pc <= o_inst_addr;
          if (i_redirect || redir_pend) state <= DRAIN;
          else begin
            state <= DATA;
            fetch_pc <= fetch_pc + STEP;
          end
        end else if (i_redirect) redir_pend <= 1'b1;
        DATA: if (i_inst_readdatavalid) begin
          beats_left <= beats_left - BW'(1);
          beat_pc <= beat_pc + ADDR_W'(4);
          if (beat_last) begin
            state <= IDLE;
            o_busy <= 1'b0;
          end else if (i_redirect) state <= DRAIN;
        end else if (i_redirect) state <= DRAIN;
        DRAIN: if (i_inst_readdatavalid) begin
          beats_left <= beats_left - BW'(1);
          if (beat_last) begin
            state <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef INST_PREFETCH_STATS_EN
  logic discard;
  assign discard = i_inst_readdatavalid && (state == DRAIN || (state == DATA && i_redirect));
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stat_words <= '0;
      o_stat_discard <= '0;
    end else begin
      if (push && !(&o_stat_words)) o_stat_words <= o_stat_words + 32'd1;
      if (discard && !(&o_stat_discard)) o_stat_discard <= o_stat_discard + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_inst_prefetch.sv
// tb_inst_prefetch: directed and random checks of inst_prefetch against a burst-slave model and a word scoreboard.
module tb_inst_prefetch;
  localparam int BURST = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk = 1'b0;
  logic rst, i_inst_waitrequest, i_inst_readdatavalid, i_redirect, i_ready;
  logic o_inst_read, o_valid, o_busy;
  logic [31:0] o_inst_addr, i_inst_readdata, i_redirect_pc, o_inst, o_pc;
  logic [7:0] o_inst_burstcount;
  int passed = 0, total = 0;
  int p_wait = 0, p_gap = 0, force_wait = 0, sl_left = 0, sl_delay = 0, reqs = 0;
  logic hold_beat = 1'b0, live = 1'b0, dead = 1'b0;
  logic [31:0] exp_addr = RESET_PC, sl_pc = '0;
  logic [31:0] q[$], seen[$], req_addrs[$];

  inst_prefetch #(.BURST(BURST), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .o_inst_addr(o_inst_addr), .o_inst_burstcount(o_inst_burstcount), .o_inst_read(o_inst_read),
    .i_inst_waitrequest(i_inst_waitrequest), .i_inst_readdata(i_inst_readdata),
    .i_inst_readdatavalid(i_inst_readdatavalid), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_inst(o_inst), .o_pc(o_pc), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(logic [31:0] pc);
    return (pc * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: drive the slave, let the edge happen, then update the scoreboard and compare.
  task automatic tick();
    logic pre_read, pre_valid, acc, beat;
    logic [31:0] pre_addr;
    int qs_pre;
    i_inst_waitrequest = force_wait > 0 || sl_left > 0 || $urandom_range(99) < p_wait;
    beat = sl_left > 0 && sl_delay == 0 && !hold_beat && $urandom_range(99) >= p_gap;
    i_inst_readdatavalid = beat;
    i_inst_readdata = beat ? f(sl_pc) : $urandom();
    pre_read = o_inst_read === 1'b1;
    pre_valid = o_valid === 1'b1;
    pre_addr = o_inst_addr;
    qs_pre = q.size();
    acc = pre_read && !i_inst_waitrequest;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      live = 1'b0;
      dead = 1'b0;
      exp_addr = RESET_PC;
      chk("rst_read", o_inst_read, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_addr", o_inst_addr, RESET_PC);
      chk("rst_inst", o_inst, 0);
      chk("rst_pc", o_pc, 0);
    end else begin
      if (pre_valid && i_ready && q.size() > 0) seen.push_back(q.pop_front());
      if (beat && live && !i_redirect) q.push_back(sl_pc);
      if (acc) begin
        live = !dead && !i_redirect;
        if (live) exp_addr = pre_addr + 32'd16;
        chk("accept_drop", o_inst_read, 0);
      end else if (pre_read) begin
        chk("stall_read", o_inst_read, 1);
        chk("stall_addr", o_inst_addr, pre_addr);
      end
      if (i_redirect) begin
        q.delete();
        live = 1'b0;
        dead = 1'b1;
        exp_addr = i_redirect_pc;
      end
      if (!pre_read && o_inst_read === 1'b1) begin
        reqs++;
        req_addrs.push_back(o_inst_addr);
        chk("req_addr", o_inst_addr, exp_addr);
        chk("req_room", 32'(qs_pre <= DEPTH - BURST), 1);
        chk("burstcount", 32'(o_inst_burstcount), BURST);
        dead = 1'b0;
      end
    end
    chk("valid", o_valid, 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("pc", o_pc, q[0]);
      chk("inst", o_inst, f(q[0]));
    end
    if (beat) begin
      sl_pc += 4;
      sl_left--;
    end
    if (sl_delay > 0) sl_delay--;
    if (acc) begin
      sl_left = BURST;
      sl_pc = pre_addr;
      sl_delay = 1;
    end
    if (force_wait > 0) force_wait--;
    i_redirect = 1'b0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_mid_burst();
    for (int i = 0; i < 60 && !(sl_left == 3 && live); i++) tick();
    chk("mid_burst_reached", 32'(sl_left == 3 && live), 1);
  endtask

  initial begin
    int mark, r0;
    rst = 1'b1;
    i_ready = 1'b1;
    i_redirect = 1'b0;
    i_redirect_pc = '0;
    i_inst_waitrequest = 1'b0;
    i_inst_readdatavalid = 1'b0;
    i_inst_readdata = '0;
    ticks(2);
    rst = 1'b0;
    tick();
    chk("first_req", o_inst_read, 1);
    chk("first_addr", o_inst_addr, RESET_PC);
    chk("first_busy", o_busy, 1);
    ticks(40);
    for (int i = 0; i < 8; i++) chk("stream_pc", seen.size() > i ? seen[i] : 32'hDEAD_BEEF, 32'(4 * i));
    chk("second_burst_addr", req_addrs.size() > 1 ? req_addrs[1] : 32'hDEAD_BEEF, 32'h10);
    // Decode stalled: two bursts fill the FIFO, then refill waits for four pops.
    i_ready = 1'b0;
    i_redirect = 1'b1;
    i_redirect_pc = 32'h40;
    tick();
    ticks(40);
    chk("full_head", o_pc, 32'h40);
    chk("full_valid", o_valid, 1);
    chk("full_idle_busy", o_busy, 0);
    chk("full_no_read", o_inst_read, 0);
    r0 = reqs;
    i_ready = 1'b1;
    ticks(3);
    i_ready = 1'b0;
    ticks(8);
    chk("no_req_at_5", reqs, r0);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    ticks(3);
    chk("req_at_4", reqs, r0 + 1);
    i_ready = 1'b1;
    ticks(20);
    // Slave stall of five cycles.
    for (int i = 0; i < 60 && o_inst_read !== 1'b1; i++) tick();
    chk("stall_req_seen", o_inst_read, 1);
    force_wait = 5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", o_inst_read, 1);
    end
    tick();
    chk("stall_first_low", o_inst_read, 0);
    // Redirect after one beat of a burst.
    wait_mid_burst();
    hold_beat = 1'b1;
    i_redirect = 1'b1;
    i_redirect_pc = 32'h100;
    tick();
    hold_beat = 1'b0;
    chk("redir_valid", o_valid, 0);
    mark = seen.size();
    ticks(30);
    chk("redir_first_pc", seen.size() > mark ? seen[mark] : 32'hDEAD_BEEF, 32'h100);
    // Address wrap at the top of the space.
    i_redirect = 1'b1;
    i_redirect_pc = 32'hFFFF_FFF0;
    tick();
    mark = seen.size();
    ticks(30);
    for (int i = 0; i < 6; i++)
      chk("wrap_pc", seen.size() > mark + i ? seen[mark + i] : 32'hDEAD_BEEF, 32'hFFFF_FFF0 + 32'(4 * i));
    // Reset in the middle of a burst while beats keep arriving.
    wait_mid_burst();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    mark = seen.size();
    tick();
    chk("post_rst_req", o_inst_read, 1);
    chk("post_rst_addr", o_inst_addr, RESET_PC);
    ticks(30);
    chk("post_rst_first_pc", seen.size() > mark ? seen[mark] : 32'hDEAD_BEEF, RESET_PC);
    // Random traffic.
    p_wait = 30;
    p_gap = 30;
    mark = seen.size();
    for (int i = 0; i < 2500; i++) begin
      i_ready = $urandom_range(99) < 70;
      if ($urandom_range(99) < 3) begin
        i_redirect = 1'b1;
        i_redirect_pc = $urandom_range(3) == 0 ? 32'hFFFF_FFE0 + 32'(4 * $urandom_range(7)) : ($urandom() & ~32'h3);
      end
      tick();
    end
    chk("random_progress", 32'(seen.size() - mark > 100), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/inst_prefetch.md
# inst_prefetch

Instruction prefetch stage between the instruction-memory Avalon-MM burst master port and the decode stage of the CPU core. Issues fixed-length burst reads starting at the current fetch PC and buffers returned words with their PCs in a small FIFO. Presents them to decode under a valid/ready handshake. Supports a pipeline redirect (branch/jump/exception) that flushes buffered words and discards in-flight beats.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, instruction word width
- `BURST`, 4, words per burst read; power of 2, ≤ `DEPTH`
- `DEPTH`, 8, FIFO entries; power of 2
- `RESET_PC`, 32'h0000_0000, fetch PC after reset

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `o_inst_addr`  out  ADDR_W  burst start byte address
- `o_inst_burstcount`  out  8  constant `BURST`
- `o_inst_read`  out  1  burst read request
- `i_inst_waitrequest`  in  1  slave stall; request held while high
- `i_inst_readdata`  in  DATA_W  returned beat
- `i_inst_readdatavalid`  in  1  beat valid
- `i_redirect`  in  1  one-cycle redirect strobe
- `i_redirect_pc`  in  ADDR_W  new fetch PC; word aligned
- `o_inst`  out  DATA_W  instruction to decode
- `o_pc`  out  ADDR_W  PC of `o_inst`
- `o_valid`  out  1  `o_inst`/`o_pc` valid
- `i_ready`  in  1  decode accepts
- `o_busy`  out  1  high in any state but IDLE

## Operation
- FSM states: IDLE, REQ, DATA, DRAIN.
- IDLE: if FIFO free slots ≥ `BURST`, go to REQ with `o_inst_addr` = `fetch_pc`.
- REQ: `o_inst_read`=1. Accepted when `!i_inst_waitrequest`. On accept, set `beats_left`=`BURST` and `fetch_pc` += 4·`BURST`, then go to DATA.
- DATA: each `i_inst_readdatavalid` pushes {data, `beat_pc`}. `beat_pc` starts at the burst address and increments by 4. After the last beat, go to IDLE.
- Redirect:
  - FIFO is flushed and `fetch_pc` ← `i_redirect_pc`.
  - In IDLE: stay.
  - In DATA: go to DRAIN.
  - In REQ: hold the request (Avalon rule) until it is accepted, then go to DRAIN. The accepted burst's PC advance is not applied.
- DRAIN: count and discard the remaining beats, then go to IDLE. No pushes.
- A redirect during DRAIN or REQ-after-redirect only updates `fetch_pc`; the number of beats to discard is unchanged.
- Only one burst is outstanding at a time. The free-slot check guarantees no overflow, so beats are never dropped except in DRAIN.
- Pop when `o_valid && i_ready`. Simultaneous push and pop is allowed at any occupancy.
- Address arithmetic is modulo 2^`ADDR_W`; wraps silently from 32'hFFFF_FFFC to 0.

## Timing
- Reset values:
  - `o_inst_read`=0, `o_valid`=0, `o_busy`=0
  - `o_inst_addr`=`RESET_PC`, `o_inst`=0, `o_pc`=0
  - FIFO empty, state IDLE, `fetch_pc`=`RESET_PC`
- First request is asserted 1 cycle after `rst` deasserts.
- Request outputs are registered and change only on the accept edge or on an IDLE→REQ edge. They are stable while `i_inst_waitrequest`=1.
- A beat arriving on edge N has `o_valid`=1 after edge N (one cycle later; FIFO output registered).
- Redirect at edge N: `o_valid`=0 after edge N, even if a beat arrives on that same edge (the beat is discarded or drained). The next request is issued no earlier than edge N+1 after reaching IDLE.
- `rst` mid-burst: everything returns to its reset value. Beats still arriving after reset are ignored, since the state is IDLE.

## Configuration
- `INST_PREFETCH_STATS_EN`: when defined, adds two 32-bit saturating output counters:
  - `o_stat_words`: words pushed
  - `o_stat_discard`: beats discarded in DRAIN
  - Both reset to 0 on `rst`.
- When undefined, these ports and the counter logic do not exist.

## Test plan
- Reset, `RESET_PC`=0, no waitrequest, beats returning 2 cycles after accept, `i_ready`=1 → decode sees words with PCs 0,4,8,…,28 in order; second burst address is 0x10.
- `i_ready`=0 → two bursts fill `DEPTH`=8. No third request until at least 4 entries are popped; `o_valid` held, with no loss or duplication.
- `i_inst_waitrequest`=1 for 5 cycles → `o_inst_read`/`o_inst_addr` stable through the stall; burst accepted on the first low cycle.
- Redirect to 0x100 after 1 of 4 beats → 3 beats discarded, `o_valid`=0; next request at 0x100; first decoded PC is 0x100. With stats enabled, `o_stat_discard`=3.
- `RESET_PC`=32'hFFFF_FFF0, `BURST`=4 → PCs FFFF_FFF0..FFFF_FFFC, then the next burst is at 0x0.
- `rst` asserted mid-DATA and beats continue for 2 cycles → all outputs at reset values; the stray beats are not pushed.
